// File: rtl/poly_wb_pkg.sv
// Shared types and constants for the polynomial MAU write-back stage.
package poly_wb_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DATA_W = 24;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 9;
endpackage

// File: rtl/poly_addr_fifo.sv
// In-flight destination address FIFO; full/empty come from the pre-cycle occupancy.
module poly_addr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/poly_mau_wb.sv
// Write-back stage: pairs MAU results with queued destination addresses and
// issues registered RAM writes, counting results against the programmed length.
module poly_mau_wb #(
  parameter int DATA_W     = poly_wb_pkg::DATA_W,
  parameter int ADDR_W     = poly_wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [poly_wb_pkg::LEN_W-1:0] len,
  input  logic                          issue_valid,
  input  logic [ADDR_W-1:0]             issue_addr,
  output logic                          issue_ready,
  input  logic                          poly_valid,
  input  logic [DATA_W-1:0]             poly_mau_o0,
  input  logic [DATA_W-1:0]             poly_mau_o1,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data0,
  output logic [DATA_W-1:0]             wr_data1,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);
  import poly_wb_pkg::*;

  state_t            state;
  logic [LEN_W-1:0]  iss_left;
  logic [LEN_W-1:0]  res_left;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W-1:0] head_addr;
  logic              run;
  logic              push;
  logic              pop;
  logic              fifo_clr;

  assign run         = (state == RUN);
  assign issue_ready = run && !fifo_full && (iss_left != '0);
  assign push        = issue_valid && issue_ready;
  assign pop         = run && poly_valid && !fifo_empty;
  assign fifo_clr    = (state == IDLE) && start;

  poly_addr_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fifo_clr),
    .push  (push),
    .pop   (pop),
    .din   (issue_addr),
    .dout  (head_addr),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      iss_left <= '0;
      res_left <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data0 <= '0;
      wr_data1 <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= pop;
      done  <= 1'b0;
      if (pop) begin
        wr_addr  <= head_addr;
        wr_data0 <= poly_mau_o0;
        wr_data1 <= poly_mau_o1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            iss_left <= len;
            res_left <= len;
            err      <= 1'b0;
            busy     <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (push) iss_left <= iss_left - 1'b1;
          if ((issue_valid && !issue_ready) || (poly_valid && fifo_empty)) err <= 1'b1;
          if (pop) begin
            res_left <= res_left - 1'b1;
            // done is raised alongside the final write so both appear on the same cycle
            if (res_left == LEN_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
